drr_dequeue_ctrl: RTL and testbench

Packet dequeue sequencer that sits between the DRR scheduler and the per-flow packet queues.
- Accepts one grant at a time: queue index plus valid, with a ready back to the scheduler.
- Pops the granted queue's head packet word by word onto a valid/ready packet stream with SOP/EOP framing.
- Holds off further grants until the packet's last word has been accepted downstream.

---
 rtl/drr_dequeue_ctrl.sv | 155 +++++++++++++++
 tb/tb_drr_dequeue_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/drr_dequeue_ctrl.sv
// DRR dequeue sequencer: takes one queue grant, streams that queue's head packet with SOP/EOP framing.
// Optional per-queue packet/byte statistics with a registered read port: define DRR_DEQ_STATS_EN.
module drr_dequeue_ctrl #(
    parameter int PKT_QS_CNT = 4,
    parameter int DATA_W     = 64,
    localparam int IDX_W     = $clog2(PKT_QS_CNT),
    localparam int BW        = DATA_W / 8,
    localparam int LOG_BW    = $clog2(BW),
    localparam int EMP_W     = (BW > 1) ? $clog2(BW) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [IDX_W-1:0]             sched_idx_i,
    input  logic                         sched_val_i,
    output logic                         sched_ready_o,
    input  logic [PKT_QS_CNT*16-1:0]     size_i,
    input  logic [PKT_QS_CNT*DATA_W-1:0] q_data_i,
    input  logic [PKT_QS_CNT-1:0]        q_empty_i,
    output logic [PKT_QS_CNT-1:0]        q_rd_o,
    output logic [DATA_W-1:0]            pkt_data_o,
    output logic                         pkt_val_o,
    output logic                         pkt_sop_o,
    output logic                         pkt_eop_o,
    output logic [EMP_W-1:0]             pkt_empty_o,
    input  logic                         pkt_ready_i,
    output logic                         busy_o,
`ifdef DRR_DEQ_STATS_EN
    input  logic [IDX_W-1:0]             stat_sel_i,
    output logic [31:0]                  stat_pkts_o,
    output logic [31:0]                  stat_bytes_o,
`endif
    output logic                         err_o
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_XFER = 1'b1;

    logic             state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [16:0]      words_q, words_d;
    logic [EMP_W-1:0] pad_q, pad_d;
    logic [15:0]      sz_q, sz_d;
    logic             first_q, first_d;
    logic             err_q, err_d;

    logic [15:0]      sz_sel;
    logic [16:0]      words_calc;
    logic [EMP_W-1:0] pad_calc;
    logic             xfer, head_empty, hs, last;
    logic [DATA_W-1:0] head_data;

    assign sz_sel     = size_i[int'(sched_idx_i)*16 +: 16];
    assign words_calc = ({1'b0, sz_sel} + 17'(BW - 1)) >> LOG_BW;
    // Unused bytes in the last word: (BW - sz mod BW) mod BW, i.e. the negated low bits.
    assign pad_calc   = (BW > 1) ? (EMP_W'(0) - sz_sel[EMP_W-1:0]) : '0;

    assign xfer       = (state_q == ST_XFER);
    assign head_empty = q_empty_i[idx_q];
    assign head_data  = q_data_i[int'(idx_q)*DATA_W +: DATA_W];
    assign last       = (words_q == 17'd1);

    assign pkt_val_o     = xfer & ~head_empty;
    assign hs            = pkt_val_o & pkt_ready_i;
    assign pkt_data_o    = xfer ? head_data : '0;
    assign pkt_sop_o     = pkt_val_o & first_q;
    assign pkt_eop_o     = pkt_val_o & last;
    assign pkt_empty_o   = pkt_eop_o ? pad_q : '0;
    assign sched_ready_o = ~xfer;
    assign busy_o        = xfer;
    assign err_o         = err_q;

    always_comb begin
        q_rd_o = '0;
        if (hs) q_rd_o[idx_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        words_d = words_q;
        pad_d   = pad_q;
        sz_d    = sz_q;
        first_d = first_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (sched_val_i) begin
                    idx_d   = sched_idx_i;
                    words_d = words_calc;
                    pad_d   = pad_calc;
                    sz_d    = sz_sel;
                    first_d = 1'b1;
                    // A zero-size grant is dropped and flagged; nothing is popped.
                    if (sz_sel == 16'd0) err_d = 1'b1;
                    else                 state_d = ST_XFER;
                end
            end
            default: begin
                if (hs) begin
                    words_d = words_q - 17'd1;
                    first_d = 1'b0;
                    if (last) state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            words_q <= '0;
            pad_q   <= '0;
            sz_q    <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            pad_q   <= pad_d;
            sz_q    <= sz_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

`ifdef DRR_DEQ_STATS_EN
    logic [31:0] pkt_cnt_q  [PKT_QS_CNT];
    logic [31:0] byte_cnt_q [PKT_QS_CNT];

    // Counters advance only on the EOP handshake, so an aborted packet is never counted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < PKT_QS_CNT; i++) begin
                pkt_cnt_q[i]  <= '0;
                byte_cnt_q[i] <= '0;
            end
            stat_pkts_o  <= '0;
            stat_bytes_o <= '0;
        end else begin
            if (hs && last) begin
                pkt_cnt_q[idx_q]  <= pkt_cnt_q[idx_q] + 32'd1;
                byte_cnt_q[idx_q] <= byte_cnt_q[idx_q] + {16'd0, sz_q};
            end
            stat_pkts_o  <= pkt_cnt_q[stat_sel_i];
            stat_bytes_o <= byte_cnt_q[stat_sel_i];
        end
    end
`else
    logic unused_sz;
    assign unused_sz = ^sz_q;
`endif

endmodule

// File: tb/tb_drr_dequeue_ctrl.sv
// Bench for drr_dequeue_ctrl: FWFT queue models feed the DUT; expected framing comes from packet sizes.
module tb_drr_dequeue_ctrl;
  localparam int NQ = 4;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    sched_idx;
  logic          sched_val;
  logic          sched_ready;
  logic [NQ*16-1:0] size_v;
  logic [NQ*DW-1:0] q_data;
  logic [NQ-1:0] q_empty;
  logic [NQ-1:0] q_rd;
  logic [DW-1:0] pkt_data;
  logic          pkt_val, pkt_sop, pkt_eop;
  logic [2:0]    pkt_empty;
  logic          pkt_ready;
  logic          busy, err;
`ifdef DRR_DEQ_STATS_EN
  logic [1:0]    stat_sel;
  logic [31:0]   stat_pkts, stat_bytes;
  logic [31:0]   exp_pkts [NQ];
  logic [31:0]   exp_bytes [NQ];
`endif

  int checks = 0;
  int errors = 0;
  logic exp_err = 1'b0;
  logic [31:0] seq  [NQ];
  logic [31:0] salt [NQ];

  always #5 clk = ~clk;

  drr_dequeue_ctrl #(.PKT_QS_CNT(NQ), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .sched_idx_i(sched_idx), .sched_val_i(sched_val), .sched_ready_o(sched_ready),
    .size_i(size_v), .q_data_i(q_data), .q_empty_i(q_empty), .q_rd_o(q_rd),
    .pkt_data_o(pkt_data), .pkt_val_o(pkt_val), .pkt_sop_o(pkt_sop), .pkt_eop_o(pkt_eop),
    .pkt_empty_o(pkt_empty), .pkt_ready_i(pkt_ready), .busy_o(busy),
`ifdef DRR_DEQ_STATS_EN
    .stat_sel_i(stat_sel), .stat_pkts_o(stat_pkts), .stat_bytes_o(stat_bytes),
`endif
    .err_o(err)
  );

  function automatic logic [63:0] word_of(input int q, input logic [31:0] s);
    return {8'(q) ^ 8'hC3, salt[q][23:0], s};
  endfunction

  // Each queue is an endless FWFT stream whose head word encodes (queue, position).
  always_comb begin
    for (int i = 0; i < NQ; i++) q_data[i*DW +: DW] = word_of(i, seq[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < NQ; i++) if (q_rd[i]) seq[i] <= seq[i] + 32'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 64'(sched_ready), 64'd1);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_val"},   64'(pkt_val), 64'd0);
    chk({tag, "_rd"},    64'(q_rd), 64'd0);
    chk({tag, "_err"},   64'(err), 64'(exp_err));
  endtask

  task automatic rand_sizes();
    for (int i = 0; i < NQ; i++) size_v[i*16 +: 16] = 16'($urandom);
  endtask

  // One grant: stall_w/emp_w force ready-low / queue-empty at that word index for n cycles.
  task automatic do_pkt(input int idx, input int sz, input int rdy_pct, input int full_pct,
                        input int stall_w, input int stall_n, input int emp_w, input int emp_n);
    int words, pad, k, st, em, cyc;
    logic [31:0] start;
    logic rdy, emp;
    words = (sz + 7) / 8;
    pad   = (8 - sz % 8) % 8;
    @(negedge clk);
    size_v[idx*16 +: 16] = 16'(sz);
    sched_idx = 2'(idx);
    sched_val = 1'b1;
    pkt_ready = 1'b1;
    q_empty   = 4'($urandom);
    q_empty[idx] = 1'b0;
    #1;
    chk("grant_ready", 64'(sched_ready), 64'd1);
    chk("grant_noval", 64'(pkt_val), 64'd0);
    start = seq[idx];
    @(posedge clk);
    if (sz == 0) exp_err = 1'b1;
    k = 0; st = 0; em = 0; cyc = 0;
    while (k < words && cyc < 2000) begin
      @(negedge clk);
      sched_val = 1'($urandom_range(1));
      sched_idx = 2'($urandom_range(3));
      rand_sizes();
      if (k == emp_w && em < emp_n) begin emp = 1'b1; em++; end
      else emp = ($urandom_range(99) >= full_pct);
      if (!emp && k == stall_w && st < stall_n) begin rdy = 1'b0; st++; end
      else rdy = ($urandom_range(99) < rdy_pct);
      q_empty = 4'($urandom);
      q_empty[idx] = emp;
      pkt_ready = rdy;
      #1;
      chk("x_busy",  64'(busy), 64'd1);
      chk("x_ready", 64'(sched_ready), 64'd0);
      chk("x_val",   64'(pkt_val), 64'(!emp));
      if (!emp) begin
        chk("x_data",  pkt_data, word_of(idx, start + 32'(k)));
        chk("x_sop",   64'(pkt_sop), 64'(k == 0));
        chk("x_eop",   64'(pkt_eop), 64'(k == words - 1));
        chk("x_empty", 64'(pkt_empty), (k == words - 1) ? 64'(pad) : 64'd0);
      end
      chk("x_rd", 64'(q_rd), (!emp && rdy) ? (64'd1 << idx) : 64'd0);
      if (!emp && rdy) k++;
      cyc++;
    end
    if (k < words) chk("x_timeout", 64'(k), 64'(words));
    @(negedge clk);
    sched_val = 1'b0;
    #1;
    chk_idle("post");
    chk("pops", 64'(seq[idx] - start), 64'(words));
`ifdef DRR_DEQ_STATS_EN
    if (sz != 0) begin
      exp_pkts[idx]  = exp_pkts[idx] + 32'd1;
      exp_bytes[idx] = exp_bytes[idx] + 32'(sz);
    end
`endif
  endtask

`ifdef DRR_DEQ_STATS_EN
  task automatic chk_stats(input int q);
    @(negedge clk);
    stat_sel = 2'(q);
    @(negedge clk);
    #1;
    chk("stat_pkts",  64'(stat_pkts),  64'(exp_pkts[q]));
    chk("stat_bytes", 64'(stat_bytes), 64'(exp_bytes[q]));
  endtask
`endif

  initial begin
    rst_n = 1'b0; sched_idx = '0; sched_val = 1'b0; size_v = '0;
    q_empty = '1; pkt_ready = 1'b0;
    for (int i = 0; i < NQ; i++) begin seq[i] = 32'd0; salt[i] = $urandom; end
`ifdef DRR_DEQ_STATS_EN
    stat_sel = '0;
    for (int i = 0; i < NQ; i++) begin exp_pkts[i] = '0; exp_bytes[i] = '0; end
`endif
    repeat (3) @(negedge clk);
    #1;
    chk_idle("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_idle("rel");
    chk("rel_sop", 64'(pkt_sop), 64'd0);

    do_pkt(2, 20, 100, 100, -1, 0, -1, 0);
    do_pkt(2, 20, 100, 100, 1, 5, -1, 0);
    do_pkt(1, 24, 100, 100, -1, 0, 1, 3);
    do_pkt(0, 0, 100, 100, -1, 0, -1, 0);
    do_pkt(3, 8, 100, 100, -1, 0, -1, 0);

    // Reset in the middle of word 2 of a 4-word packet.
    @(negedge clk);
    size_v[3*16 +: 16] = 16'd32; sched_idx = 2'd3; sched_val = 1'b1;
    q_empty = '0; pkt_ready = 1'b1;
    @(negedge clk);
    sched_val = 1'b0;
    #1;
    chk("r_sop", 64'(pkt_sop), 64'd1);
    @(negedge clk);
    pkt_ready = 1'b0;
    #1;
    chk("r_w2val", 64'(pkt_val), 64'd1);
    chk("r_w2sop", 64'(pkt_sop), 64'd0);
    #2;
    rst_n = 1'b0;
    pkt_ready = 1'b1;
    #1;
    exp_err = 1'b0;
    chk_idle("arst");
    chk("arst_sop",  64'(pkt_sop), 64'd0);
    chk("arst_eop",  64'(pkt_eop), 64'd0);
    chk("arst_data", pkt_data, 64'd0);
    chk("arst_emp",  64'(pkt_empty), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef DRR_DEQ_STATS_EN
    for (int i = 0; i < NQ; i++) begin exp_pkts[i] = '0; exp_bytes[i] = '0; end
`endif
    do_pkt(0, 16, 100, 100, -1, 0, -1, 0);
    do_pkt(2, 20, 100, 100, -1, 0, -1, 0);
    do_pkt(2, 8, 100, 100, -1, 0, -1, 0);
`ifdef DRR_DEQ_STATS_EN
    chk_stats(2);
`endif

    for (int n = 0; n < 40; n++) begin
      int rsz;
      rsz = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(200, 1));
      do_pkt(int'($urandom_range(3)), rsz, 60, 75, -1, 0, -1, 0);
    end
`ifdef DRR_DEQ_STATS_EN
    for (int q = 0; q < NQ; q++) chk_stats(q);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
